sequential_divider: RTL and testbench
=====================================

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled on a rising clk edge.
REQ-005 SHALL have port dividend  input  WIDTH  signed two's-complement dividend; sampled only when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  signed two's-complement divisor; sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results are valid on this cycle.
REQ-009 SHALL have port quotient  output  WIDTH  signed quotient.
REQ-010 SHALL have port remainder  output  WIDTH  signed remainder.
REQ-011 SHALL have port div_by_zero  output  1  high when the last accepted divisor was 0.
REQ-012 SHALL have port overflow  output  1  high when the last accepted operation was -2^(WIDTH-1) / -1.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE: start=1 SHALL latch the operands, record the result signs, load the operand magnitudes, and go to CALC (or to DONE when divisor=0).
REQ-015 CALC SHALL perform one restoring shift/subtract iteration per cycle, for exactly WIDTH cycles, then go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then go to IDLE; start=1 in DONE SHALL be accepted as in IDLE, allowing back-to-back operations.
REQ-017 Latency: for start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH+1 (WIDTH+1 cycles); for divide-by-zero, in the cycle after edge N+1.
REQ-018 busy SHALL be high in CALC and low in IDLE and DONE.
REQ-019 start while busy=1 SHALL be ignored; the in-flight operation and its operands SHALL be unaffected.
REQ-020 Quotient SHALL truncate toward zero; its sign SHALL be the XOR of the operand signs.
REQ-021 Remainder SHALL carry the dividend's sign and satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
REQ-022 Magnitude arithmetic SHALL use WIDTH+1 bits internally, so that |-2^(WIDTH-1)| is exact.
REQ-023 Divisor=0 SHALL give quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
REQ-024 Dividend=-2^(WIDTH-1) with divisor=-1 SHALL give quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1.
REQ-025 quotient, remainder, div_by_zero and overflow SHALL update only on entry to DONE and hold until the next DONE.
REQ-026 Flags SHALL be cleared on the accept of any new operation that does not set them.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and drive busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, regardless of clk.
REQ-028 rst asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-029 Sign cases (WIDTH=32): 7/2 -> q=3 r=1; -7/2 -> q=-3 r=-1; 7/-2 -> q=-3 r=1; -7/-2 -> q=3 r=-1; each with done exactly 33 cycles after start and busy high for 32 cycles.
REQ-030 Edge magnitudes: -4294836225 truncated to 32 bits is not used; instead -131070/65535 -> q=-2 r=0, and 2147483647/1 -> q=2147483647 r=0.
REQ-031 Divide-by-zero: 5/0 -> done on the 2nd cycle, q=-1, r=5, div_by_zero=1; then 6/3 -> q=2 r=0, div_by_zero=0.
REQ-032 Overflow: -2147483648/-1 -> q=-2147483648, r=0, overflow=1.
REQ-033 Busy/back-to-back: start 100/7 with a second start 9/3 pulsed at cycle 10 -> result q=14 r=2 only (the cycle-10 start is ignored); start 9/3 during DONE -> q=3 r=0 after a further 33 cycles.
REQ-034 Reset mid-op: start 100/7, assert rst at cycle 15 -> all outputs 0 immediately and no done pulse; after release, 8/-3 -> q=-2 r=2.

Source files
------------

// File: rtl/sequential_divider.sv
// Signed sequential divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per cycle, sign correction applied when the result is loaded.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Magnitude in WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  function automatic logic [WIDTH:0] abs_ext(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    if (v[WIDTH-1]) begin
      abs_ext = ~ext + (WIDTH+1)'(1);
    end else begin
      abs_ext = ext;
    end
  endfunction

  // Two's-complement negate when neg is set; also yields an unsigned magnitude.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    if (neg) begin
      apply_sign = ~mag + WIDTH'(1);
    end else begin
      apply_sign = mag;
    end
  endfunction

  state_e           state_q;
  logic [WIDTH:0]   rem_q;       // partial remainder
  logic [WIDTH:0]   dvs_q;       // divisor magnitude
  logic [WIDTH-1:0] acc_q;       // dividend bits shifting out, quotient bits shifting in
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             ovf_pend_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             ovf_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rmd_q;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] acc_d;
  logic             fit_s;
  logic             accept_s;
  logic             zero_div_s;
  logic             ovf_s;

  // One restoring iteration: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    shift_s = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    fit_s   = rem_q[WIDTH] | (shift_s >= dvs_q);
    if (fit_s) begin
      rem_d = shift_s - dvs_q;
    end else begin
      rem_d = shift_s;
    end
    acc_d = {acc_q[WIDTH-2:0], fit_s};
  end

  // Request acceptance and special-case detection on the live operands.
  always_comb begin
    accept_s   = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    zero_div_s = (divisor == ZERO_W);
    ovf_s      = (dividend == MIN_NEG) & (divisor == ALL_ONES);
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      quot_q     <= '0;
      rmd_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept_s) begin
            rem_q      <= '0;
            dvs_q      <= abs_ext(divisor);
            acc_q      <= apply_sign(dividend, dividend[WIDTH-1]);
            cnt_q      <= CW'(WIDTH - 1);
            q_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q    <= dividend[WIDTH-1];
            ovf_pend_q <= ovf_s;
            if (zero_div_s) begin
              // Divide by zero skips the iterations entirely.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= ALL_ONES;
              rmd_q   <= dividend;
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          if (cnt_q == CW'(0)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= apply_sign(acc_d, q_neg_q);
            rmd_q   <= apply_sign(rem_d[WIDTH-1:0], r_neg_q);
            dbz_q   <= 1'b0;
            ovf_q   <= ovf_pend_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed sign/edge cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_sequential_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division in 64-bit arithmetic, then the special cases.
  task automatic model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    longint la;
    longint lb;
    la = longint'(a);
    lb = longint'(b);
    if (lb == 0) begin
      q  = {W{1'b1}};
      r  = a;
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      q  = W'(la / lb);
      r  = W'(la % lb);
      dz = 1'b0;
      ov = (la == -64'sd2147483648) && (lb == -64'sd1);
    end
  endtask

  // Drive start for exactly one sampling edge, then scramble the operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
  endtask

  // Count cycles after the accept edge until done; optionally pulse a start at inj_cyc.
  task automatic wait_done(input int inj_cyc, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else if (c == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) check_eq("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int lat, input int bcnt);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ed;
    logic         eo;
    model(a, b, eq, er, ed, eo);
    check_eq("latency",  64'(lat),  (b == '0) ? 64'd1 : 64'd33);
    check_eq("busy_cyc", 64'(bcnt), (b == '0) ? 64'd0 : 64'd32);
    check_eq("quotient", {32'd0, quotient},  {32'd0, eq});
    check_eq("remainder", {32'd0, remainder}, {32'd0, er});
    check_eq("div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
    check_eq("overflow", {63'd0, overflow}, {63'd0, eo});
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int bcnt;
    logic [W-1:0] q_seen;
    issue(a, b);
    wait_done(-5, '0, '0, lat, bcnt);
    check_result(a, b, lat, bcnt);
    q_seen = quotient;
    @(negedge clk);
    check_eq("done_pulse", {63'd0, done}, 64'd0);
    check_eq("q_hold", {32'd0, quotient}, {32'd0, q_seen});
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int tmp;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_q",    {32'd0, quotient}, 64'd0);
    check_eq("rst_r",    {32'd0, remainder}, 64'd0);
    check_eq("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    check_eq("rst_ovf",  {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sign cases and edge magnitudes.
    run_op(32'd7, 32'd2);
    run_op(-32'sd7, 32'd2);
    run_op(32'd7, -32'sd2);
    run_op(-32'sd7, -32'sd2);
    run_op(-32'sd131070, 32'd65535);
    run_op(32'd2147483647, 32'd1);
    run_op(32'd5, 32'd0);
    run_op(32'd6, 32'd3);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd6, 32'd3);

    // Start while busy is ignored; start during DONE is accepted.
    issue(32'd100, 32'd7);
    wait_done(10, 32'd9, 32'd3, lat, bcnt);
    check_result(32'd100, 32'd7, lat, bcnt);
    issue(32'd9, 32'd3);
    wait_done(-5, '0, '0, lat, bcnt);
    check_result(32'd9, 32'd3, lat, bcnt);
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse.
    issue(32'd100, 32'd7);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_done", {63'd0, done}, 64'd0);
    check_eq("mid_rst_q",    {32'd0, quotient}, 64'd0);
    check_eq("mid_rst_r",    {32'd0, remainder}, 64'd0);
    check_eq("mid_rst_flag", {62'd0, div_by_zero, overflow}, 64'd0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq("no_done_after_rst", 64'(dcnt), 64'd0);
    run_op(32'd8, -32'sd3);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      a = $urandom();
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: begin
          tmp = int'($urandom_range(0, 40)) - 20;
          b   = tmp;
        end
        4: begin
          tmp = int'($urandom_range(0, 2000)) - 1000;
          a   = tmp;
          b   = $urandom();
        end
        default: b = $urandom();
      endcase
      run_op(a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
